// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0): one MSB-first, full-duplex byte per
// accepted start request, with SS framing each byte individually and a
// guaranteed SS-high gap before the next byte can begin.
module spi_master #(
    parameter int CLK_DIV   = 2,
    parameter int BYTE_SIZE = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic [BYTE_SIZE-1:0] data_to_send,
    input  logic                 MISO,
    output logic                 SCLK,
    output logic                 MOSI,
    output logic                 SS,
    output logic [BYTE_SIZE-1:0] received_data,
    output logic                 data_valid,
    output logic                 busy
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(BYTE_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD,
        GAP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [CNT_W-1:0]       div_cnt;
    logic [CNT_W-1:0]       div_cnt_nxt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [BIT_W-1:0]       bit_cnt_nxt;
    logic [BYTE_SIZE-1:0]   tx_shift;
    logic [BYTE_SIZE-1:0]   tx_shift_nxt;
    logic [BYTE_SIZE-1:0]   rx_shift;
    logic [BYTE_SIZE-1:0]   rx_shift_nxt;

    logic                   sclk_nxt;
    logic                   mosi_nxt;
    logic                   ss_nxt;
    logic [BYTE_SIZE-1:0]   received_data_nxt;
    logic                   data_valid_nxt;
    logic                   busy_nxt;

    // A tick marks the last system-clock cycle of an SCLK half-period.
    logic                   tick;
    assign tick = (div_cnt == CNT_LAST);

    // State register; reset drops any transfer in flight immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic; every SPI pin is registered so the
    // link sees glitch-free edges aligned to the system clock.
    always_comb begin
        state_nxt         = state;
        div_cnt_nxt       = div_cnt;
        bit_cnt_nxt       = bit_cnt;
        tx_shift_nxt      = tx_shift;
        rx_shift_nxt      = rx_shift;
        sclk_nxt          = SCLK;
        mosi_nxt          = MOSI;
        ss_nxt            = SS;
        received_data_nxt = received_data;
        data_valid_nxt    = 1'b0;
        busy_nxt          = busy;

        // The half-period counter only runs while a byte is in progress,
        // so the first tick lands exactly CLK_DIV cycles after acceptance.
        if (state != IDLE) begin
            div_cnt_nxt = tick ? '0 : div_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                div_cnt_nxt = '0;
                if (start) begin
                    tx_shift_nxt = data_to_send;
                    ss_nxt       = 1'b0;
                    mosi_nxt     = data_to_send[BYTE_SIZE-1];
                    busy_nxt     = 1'b1;
                    bit_cnt_nxt  = '0;
                    state_nxt    = SETUP;
                end
            end

            SETUP: begin
                // MSB has been on MOSI for one half-period; raise SCLK and
                // capture the slave's first bit on the same edge.
                if (tick) begin
                    sclk_nxt     = 1'b1;
                    rx_shift_nxt = {rx_shift[BYTE_SIZE-2:0], MISO};
                    state_nxt    = TRANSFER;
                end
            end

            TRANSFER: begin
                if (tick) begin
                    if (!SCLK) begin
                        sclk_nxt     = 1'b1;
                        rx_shift_nxt = {rx_shift[BYTE_SIZE-2:0], MISO};
                    end else begin
                        sclk_nxt    = 1'b0;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (bit_cnt_nxt < BIT_LAST) begin
                            // Rotate so the next bit to send sits at the MSB.
                            tx_shift_nxt = {tx_shift[BYTE_SIZE-2:0],
                                            tx_shift[BYTE_SIZE-1]};
                            mosi_nxt     = tx_shift[BYTE_SIZE-2];
                        end else begin
                            // Last falling edge: MOSI keeps the final bit.
                            state_nxt = HOLD;
                        end
                    end
                end
            end

            HOLD: begin
                if (tick) begin
                    ss_nxt            = 1'b1;
                    received_data_nxt = rx_shift;
                    data_valid_nxt    = 1'b1;
                    state_nxt         = GAP;
                end
            end

            GAP: begin
                // SS stays high here for a full half-period so consecutive
                // bytes are always separated on the wire.
                if (tick) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counters, shift registers and registered SPI/host outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt       <= '0;
            bit_cnt       <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            SCLK          <= 1'b0;
            MOSI          <= 1'b0;
            SS            <= 1'b1;
            received_data <= '0;
            data_valid    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            div_cnt       <= div_cnt_nxt;
            bit_cnt       <= bit_cnt_nxt;
            tx_shift      <= tx_shift_nxt;
            rx_shift      <= rx_shift_nxt;
            SCLK          <= sclk_nxt;
            MOSI          <= mosi_nxt;
            SS            <= ss_nxt;
            received_data <= received_data_nxt;
            data_valid    <= data_valid_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) master that drives SCLK, MOSI and SS towards the team's spi_slave and captures MISO. Runs from one system clock.
- Each start request performs one BYTE_SIZE-bit, MSB-first, full-duplex transfer. SS is asserted for that byte only, matching the per-byte SS framing spi_slave is exercised with.
- Sits between on-chip control logic and the off-chip or peer SPI link.

Parameters:
- CLK_DIV, 2: system-clock cycles per SCLK half-period; legal range >=1 (CLK_DIV=1 gives SCLK=CLK/2).
- BYTE_SIZE, 8: bits per transfer.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  transfer request; sampled only when busy=0.
- data_to_send  input  BYTE_SIZE  byte to transmit; captured in the cycle start is accepted.
- MISO  input  1  serial data from slave.
- SCLK  output  1  SPI clock, registered, idle low.
- MOSI  output  1  serial data to slave, registered.
- SS  output  1  active-low slave select, registered, idle high.
- received_data  output  BYTE_SIZE  last completed received byte; holds until next completion.
- data_valid  output  1  one-cycle pulse when received_data updates.
- busy  output  1  high from start acceptance until return to IDLE.

Behaviour:
- Reset values (asynchronous, immediate): SCLK=0, MOSI=0, SS=1, received_data=0, data_valid=0, busy=0; FSM in IDLE; counters and shift registers cleared.
- Half-period counter: counts 0..CLK_DIV-1; a "tick" is the cycle it wraps. Width is clog2(CLK_DIV), minimum 1.
- FSM states: IDLE, SETUP, TRANSFER, HOLD, GAP.
- IDLE: if start=1, on that edge:
  - tx_shift<=data_to_send; SS<=0; MOSI<=data_to_send[BYTE_SIZE-1]; busy<=1.
  - Bit counter cleared; go to SETUP.
  - With start=0, outputs are held.
- SETUP: on tick, SCLK<=1 (rising edge 1) and rx_shift<={rx_shift[BYTE_SIZE-2:0],MISO}; go to TRANSFER.
- TRANSFER: on each tick, toggle SCLK.
  - Going high: shift MISO into rx_shift.
  - Going low: increment bit count; if count<BYTE_SIZE, drive MOSI with the next tx bit (MSB first).
  - After the BYTE_SIZE-th falling edge, go to HOLD. MOSI keeps the last bit.
- HOLD: on tick, SS<=1, received_data<=rx_shift, data_valid<=1 for exactly that one cycle; go to GAP.
- GAP: on tick, busy<=0 and go to IDLE. SS stays high, guaranteeing a minimum SS-high time between bytes.
- Timing from start acceptance edge (t=0), with D=CLK_DIV:
  - SS falls at t=0.
  - Rising SCLK edges at D, 3D, …, (2·BYTE_SIZE−1)D.
  - Last falling edge at 2·BYTE_SIZE·D.
  - SS rises and data_valid pulses at (2·BYTE_SIZE+1)D.
  - busy falls at (2·BYTE_SIZE+2)D; for BYTE_SIZE=8 that is 17D and 18D.
- MISO is sampled on the system-clock edge that drives SCLK high, i.e. the value the slave set up after the previous falling edge. No synchroniser: MISO is launched from SCLK, which this block generates.
- start while busy=1 is ignored; it is neither queued nor does it alter data_to_send capture.
- start held high continuously gives back-to-back transfers with SS high for D+1 cycles between bytes.
- RESET mid-transfer aborts immediately: SS=1, SCLK=0, no data_valid, received_data cleared. The next start performs a clean full transfer.
- data_to_send changes after acceptance have no effect on the current byte.

Test Plan:
- Reset: assert RESET for 3 cycles with start=1 -> SS=1, SCLK=0, MOSI=0, busy=0, data_valid=0, received_data=0x00 throughout. No transfer starts while RESET is high.
- Loopback (MISO tied to MOSI), CLK_DIV=2, send 0xC1:
  - MOSI at the 8 rising edges = 1,1,0,0,0,0,0,1.
  - Exactly 8 SCLK pulses; SS low for 34 cycles.
  - data_valid single pulse at cycle 34 with received_data=0xC1.
  - busy low at cycle 36.
- Peer test with spi_slave instance (slave data_to_send=0xF1), master sends 0x4B -> master received_data=0xF1, slave received_data=0x4B, one data_valid on each side.
- Busy rejection: start with 0xA5, then pulse start with 0x00 at cycle 10 -> transfer completes with MOSI pattern of 0xA5, exactly one data_valid, busy never re-asserts early.
- Abort: assert RESET asynchronously between rising edges 3 and 4 -> SS=1 and SCLK=0 without waiting for CLK, no data_valid. A subsequent loopback send of 0x3C yields received_data=0x3C.
- Back-to-back, CLK_DIV=1, start held high, data_to_send 0x01 then 0x80 -> two transfers, SS high for exactly 2 cycles between them, two data_valid pulses, received_data 0x01 then 0x80 under loopback.
